// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the PMIPS data-memory bus.
// TXDATA pushes into a small FIFO; STATUS and BAUDDIV sit beside it.
module dmem_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    output logic        hit,
    output logic        tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd2;
    localparam logic [15:0] BAUD_ADDR = BASE_ADDR + 16'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [15:0]    baud_div;
    logic [15:0]    bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           overflow;
    logic           tx_q;

    logic sel_tx, sel_st, sel_bd;
    logic wr_tx, full, empty, push, pop, bit_end, busy;
    logic [15:0] div_load;
    logic [15:0] status;

    assign sel_tx   = (dmemaddr == BASE_ADDR);
    assign sel_st   = (dmemaddr == STAT_ADDR);
    assign sel_bd   = (dmemaddr == BAUD_ADDR);
    assign wr_tx    = dmemwrite && sel_tx;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = wr_tx && !full;
    assign bit_end  = (bit_cnt == 16'd0);
    assign busy     = (state != IDLE);
    // the stop bit's last edge pops directly so frames run back to back
    assign pop      = !empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));
    assign div_load = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign status   = {8'h00, 4'(count), overflow, busy, empty, full};
    assign hit      = dmemread && (sel_tx || sel_st || sel_bd);
    assign tx       = tx_q;

    always_comb begin
        dmemrdata = 16'h0000;
        if (dmemread) begin
            unique case (1'b1)
                sel_st:  dmemrdata = status;
                sel_bd:  dmemrdata = baud_div;
                default: dmemrdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= dmemwdata[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= DIV_RESET;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_tx && full) begin
                overflow <= 1'b1;
            end else if (dmemwrite && sel_st) begin
                overflow <= 1'b0;
            end
            if (dmemwrite && sel_bd) begin
                baud_div <= dmemwdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx_q    <= 1'b1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= mem[rptr];
                        tx_q    <= 1'b0;
                        bit_cnt <= div_load;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shift[0];
                        bit_idx <= 3'd0;
                        bit_cnt <= div_load;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= div_load;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= mem[rptr];
                            tx_q    <= 1'b0;
                            bit_cnt <= div_load;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_uart_tx.md
Name: dmem_uart_tx

Overview:
- Memory-mapped UART transmitter that responds to the PMIPS data-memory bus, which the processor drives through dmemaddr, dmemwdata, dmemwrite, dmemread and dmemrdata.
- Sits beside the data-memory/IO device at top level. The top level steers read data from this block whenever `hit` is high.
- Buffers bytes written by software in a small FIFO and serialises them as 8N1 frames on `tx`.

Parameters:
- BASE_ADDR, 16'hFFF0: byte address of the TXDATA register. STATUS is at BASE+2 and BAUDDIV at BASE+4.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of 2, minimum 2.
- DIV_RESET, 16'd4: BAUDDIV value after reset.

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high
- dmemaddr  in  16  bus byte address
- dmemwdata  in  16  bus write data
- dmemwrite  in  1  write enable, sampled at rising clock
- dmemread  in  1  read enable
- dmemrdata  out  16  read data, combinational
- hit  out  1  combinational. High when dmemread=1 and dmemaddr equals BASE, BASE+2 or BASE+4.
- tx  out  1  serial line, idle high

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-frame:
  - tx=1, FIFO emptied, transmitter idle.
  - BAUDDIV=DIV_RESET, overflow flag=0, bit counter=0.
- Reads are combinational, with no clock latency:
  - When dmemread=1 and the address matches, dmemrdata returns the register value.
  - Otherwise dmemrdata=0 and hit=0.
- Writes act at the rising edge when dmemwrite=1 and the address matches. Unmatched addresses are ignored.
- Register map:
  - TXDATA (BASE): write pushes dmemwdata[7:0]; the upper byte is ignored. Reads return 0.
  - STATUS (BASE+2), read-only fields:
    - bit0 full
    - bit1 empty
    - bit2 busy (frame in progress)
    - bit3 overflow, sticky
    - bits[7:4] FIFO count
    - other bits 0
  - STATUS write, any data: clears overflow.
  - BAUDDIV (BASE+4), read/write 16 bits: clocks per bit. A value of 0 behaves as 1.
- FIFO push decision uses the count before the edge:
  - A write to TXDATA while full is dropped and sets overflow, even if a pop happens at the same edge.
  - A simultaneous push and pop while not full leaves the count unchanged.
- Transmitter FSM, with states IDLE, START, DATA, STOP:
  - IDLE: tx=1. At an edge with FIFO non-empty, pop the head into the shift register and enter START.
  - START: tx=0 for one bit period.
  - DATA: 8 bit periods, LSB first; tx = shift[0], shifting right at each bit boundary.
  - STOP: tx=1 for one bit period. At its final edge:
    - FIFO non-empty: pop and go to START directly, with no idle gap between frames.
    - FIFO empty: go to IDLE.
- Bit timing:
  - A down-counter is loaded from BAUDDIV at each bit boundary.
  - A BAUDDIV write mid-frame takes effect from the next bit boundary. The current bit is unaffected.
- Latency: a TXDATA write at edge N into an empty FIFO while IDLE gives pop at edge N+1, with tx falling after edge N+1.
- Frame length is exactly 10*BAUDDIV clocks.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH wide enough to hold 0..FIFO_DEPTH.
- Register outputs are glitch-free: tx must come from a flop.

Test Plan:
- Reset values: assert reset mid-frame → tx=1 immediately. After release, STATUS read = 16'h0002 and BAUDDIV read = 4.
- Single frame: BAUDDIV=4, write 16'h1255 to BASE at edge N:
  - tx low over edges N+1..N+5.
  - Data bits 1,0,1,0,1,0,1,0, each 4 clocks.
  - tx high for the stop bit.
  - Frame total is 40 clocks, then busy=0.
- Back-to-back: write 8'hA5, 8'h3C, 8'hFF on consecutive cycles → three contiguous frames with no idle clock between them. STATUS count goes 1,2,… and then drains to 0.
- Overflow: with BAUDDIV=100 and FIFO_DEPTH=4, write 6 bytes:
  - Byte 1 is popped; bytes 2–5 fill the FIFO.
  - Byte 6 is dropped, so STATUS reads full=1, overflow=1.
  - A STATUS write clears overflow.
  - Only 5 frames are ever sent.
- Decode and read mux:
  - Read BASE+6 → hit=0, dmemrdata=0.
  - Read BASE → hit=1, dmemrdata=0.
  - dmemread=0 at BASE+4 → hit=0.
  - A write to BASE+8 changes nothing.
- Divisor change mid-frame: set BAUDDIV=2 during data bit 3 of a BAUDDIV=8 frame → bit 3 still lasts 8 clocks, and bits 4–7 and the stop bit last 2 clocks each. A BAUDDIV of 0 gives 1-clock bits.
